// File: rtl/h_gate_scheduler.sv
// Hadamard pair scheduler: issues amplitude-pair reads for one target qubit and
// tracks each pair through the fixed-latency H datapath. Optional macro: H_SCHED_PERF_EN.
module h_gate_scheduler #(
  parameter int unsigned NUM_QUBITS = 3,
  parameter int unsigned TGT_W      = 2,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned PIPE_LAT   = 10
) (
  input  logic                  clk,
  input  logic                  rst_s_n,
  input  logic                  start,
  input  logic [TGT_W-1:0]      target,
  input  logic                  hold,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  rd_en,
  output logic [NUM_QUBITS-1:0] rd_addr_a,
  output logic [NUM_QUBITS-1:0] rd_addr_b,
  output logic                  wr_en,
  output logic [NUM_QUBITS-1:0] wr_addr_a,
  output logic [NUM_QUBITS-1:0] wr_addr_b
`ifdef H_SCHED_PERF_EN
  ,
  output logic [15:0]           cycle_cnt
`endif
);

  localparam int unsigned Depth    = RD_LAT + PIPE_LAT;
  localparam int unsigned KW       = (NUM_QUBITS > 1) ? NUM_QUBITS - 1 : 1;
  localparam int unsigned NumPairs = 1 << (NUM_QUBITS - 1);
  localparam logic [KW-1:0] LastK  = KW'(NumPairs - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e                state_q, state_d;
  logic [KW-1:0]         k_q;
  logic [TGT_W-1:0]      tgt_q;
  logic                  err_q;
  logic [Depth-1:0]      vld_q;
  logic [NUM_QUBITS-1:0] ta_q [Depth];
  logic [NUM_QUBITS-1:0] tb_q [Depth];

  logic                  target_ok, accept, reject, issue, pending;
  logic [NUM_QUBITS-1:0] k_ext, tgt_bit, low_mask, pair_a, pair_b;

  assign target_ok = ({1'b0, target} < (TGT_W + 1)'(NUM_QUBITS));
  assign accept    = (state_q == StIdle) && start && target_ok;
  assign reject    = (state_q == StIdle) && start && !target_ok;
  assign issue     = (state_q == StIssue) && !hold;

  // Pair base address: k with a zero spliced in at the target bit position.
  always_comb begin
    k_ext    = NUM_QUBITS'(k_q);
    tgt_bit  = NUM_QUBITS'(1) << tgt_q;
    low_mask = tgt_bit - NUM_QUBITS'(1);
    pair_a   = ((k_ext & ~low_mask) << 1) | (k_ext & low_mask);
    pair_b   = pair_a | tgt_bit;
  end

  // Stage Depth-1 is this cycle's write, so only earlier stages count as pending.
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < int'(Depth) - 1; i++) begin
      pending = pending | vld_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_s_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StIssue;
      StIssue: if (issue && (k_q == LastK)) state_d = StDrain;
      StDrain: if (!pending) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy      = (state_q == StIssue) || (state_q == StDrain);
    done      = (state_q == StDone);
    err       = err_q;
    rd_en     = issue;
    rd_addr_a = (state_q == StIssue) ? pair_a : '0;
    rd_addr_b = (state_q == StIssue) ? pair_b : '0;
    wr_en     = vld_q[Depth-1];
    wr_addr_a = ta_q[Depth-1];
    wr_addr_b = tb_q[Depth-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_s_n) begin
      k_q   <= '0;
      tgt_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= reject;
      if (accept) begin
        k_q   <= '0;
        tgt_q <= target;
      end else if (issue) begin
        k_q <= k_q + KW'(1);
      end
    end
  end

  // Bubbles carry zero addresses so idle write-back ports stay quiet.
  always_ff @(posedge clk) begin
    if (!rst_s_n) begin
      vld_q <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        ta_q[i] <= '0;
        tb_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= issue;
      ta_q[0]  <= issue ? pair_a : '0;
      tb_q[0]  <= issue ? pair_b : '0;
      for (int i = 1; i < int'(Depth); i++) begin
        vld_q[i] <= vld_q[i-1];
        ta_q[i]  <= ta_q[i-1];
        tb_q[i]  <= tb_q[i-1];
      end
    end
  end

`ifdef H_SCHED_PERF_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_s_n) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if (busy && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign cycle_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_h_gate_scheduler.sv
// Randomized bench for h_gate_scheduler against a pair-list / write-schedule model.
module tb_h_gate_scheduler;

  localparam int NQ  = 3;
  localparam int TW  = 2;
  localparam int LAT = 1 + 10;
  localparam int NP  = 1 << (NQ - 1);

  logic          clk = 1'b0;
  logic          rst_s_n, start, hold;
  logic [TW-1:0] target;
  logic          busy, done, err, rd_en, wr_en;
  logic [NQ-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
`ifdef H_SCHED_PERF_EN
  logic [15:0]   cycle_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  h_gate_scheduler dut (
    .clk       (clk),
    .rst_s_n   (rst_s_n),
    .start     (start),
    .target    (target),
    .hold      (hold),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b)
`ifdef H_SCHED_PERF_EN
    ,
    .cycle_cnt (cycle_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // hold_mode: 0 never, 1 random, 2 cycles 2-3 only
  task automatic run(input int t, input int hold_mode);
    int  pairs[$];
    int  wr_sched[int];
    int  idx = 0;
    int  last = -1;
    bit  h, exp_rd, exp_wr, exp_done, finished = 0;
    start = 1'b1; target = TW'(t); hold = 1'b0;
    @(negedge clk);
    check("idle_busy", int'(busy), 0);
    check("idle_rd_en", int'(rd_en), 0);
    next_cycle();
    start = 1'b0;
    if (t >= NQ) begin
      @(negedge clk);
      check("rej_err", int'(err), 1);
      check("rej_busy", int'(busy), 0);
      check("rej_rd_en", int'(rd_en), 0);
      check("rej_wr_en", int'(wr_en), 0);
      next_cycle();
      @(negedge clk);
      check("rej_err_clr", int'(err), 0);
      check("rej_busy2", int'(busy), 0);
      next_cycle();
      return;
    end
    for (int a = 0; a < (1 << NQ); a++) if (((a >> t) & 1) == 0) pairs.push_back(a);
    for (int cyc = 1; cyc < 200; cyc++) begin
      case (hold_mode)
        1:       h = ($urandom_range(0, 2) == 0);
        2:       h = (cyc == 2 || cyc == 3);
        default: h = 1'b0;
      endcase
      hold   = h;
      start  = ($urandom_range(0, 4) == 0);
      target = TW'($urandom_range(0, 3));
      exp_rd = (idx < NP) && !h;
      @(negedge clk);
      check("rd_en", int'(rd_en), int'(exp_rd));
      if (exp_rd) begin
        check("rd_addr_a", int'(rd_addr_a), pairs[idx]);
        check("rd_addr_b", int'(rd_addr_b), pairs[idx] | (1 << t));
        wr_sched[cyc + LAT] = pairs[idx];
        idx++;
        if (idx == NP) last = cyc + LAT;
      end
      exp_wr = wr_sched.exists(cyc);
      check("wr_en", int'(wr_en), int'(exp_wr));
      if (exp_wr) begin
        check("wr_addr_a", int'(wr_addr_a), wr_sched[cyc]);
        check("wr_addr_b", int'(wr_addr_b), wr_sched[cyc] | (1 << t));
      end
      exp_done = (last >= 0) && (cyc == last + 1);
      check("busy", int'(busy), int'((last < 0) || (cyc <= last)));
      check("done", int'(done), int'(exp_done));
      check("err_run", int'(err), 0);
`ifdef H_SCHED_PERF_EN
      if (cyc == 1) check("cnt_clear", int'(cycle_cnt), 0);
      if (exp_done) check("cnt_final", int'(cycle_cnt), last);
`endif
      if (exp_done) begin
        start = 1'b0; hold = 1'b0;
        finished = 1'b1;
        break;
      end
      next_cycle();
    end
    if (!finished) check("run_timeout", 0, 1);
    next_cycle();
  endtask

  task automatic reset_run(input int t);
    start = 1'b1; target = TW'(t); hold = 1'b0;
    next_cycle();
    start = 1'b0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      if (cyc == 8) rst_s_n = 1'b0;
      @(negedge clk);
      check("pre_rst_rd_en", int'(rd_en), int'(cyc <= NP));
      next_cycle();
    end
    rst_s_n = 1'b1;
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_rd_en", int'(rd_en), 0);
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_rd_addr", int'({rd_addr_a, rd_addr_b}), 0);
    check("rst_wr_addr", int'({wr_addr_a, wr_addr_b}), 0);
    for (int cyc = 0; cyc < 14; cyc++) begin
      next_cycle();
      @(negedge clk);
      check("post_rst_wr_en", int'(wr_en), 0);
      check("post_rst_busy", int'(busy), 0);
    end
    next_cycle();
  endtask

  initial begin
    rst_s_n = 1'b0; start = 1'b0; hold = 1'b0; target = '0;
    repeat (3) next_cycle();
    @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_err", int'(err), 0);
    check("reset_rd_en", int'(rd_en), 0);
    check("reset_wr_en", int'(wr_en), 0);
`ifdef H_SCHED_PERF_EN
    check("reset_cnt", int'(cycle_cnt), 0);
`endif
    next_cycle();
    rst_s_n = 1'b1;
    next_cycle();
    run(0, 0);
    run(2, 0);
    run(1, 2);
    run(3, 0);
    reset_run(1);
    run(0, 0);
    for (int i = 0; i < 20; i++) run($urandom_range(0, 3), 1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
